// File: rtl/vram_pkg.sv
// Shared types for the screen-memory controller: bank ids, queued write entries, arbiter states.
package vram_pkg;
    localparam int VRAM_OFS_W = 13;
    localparam int VRAM_BANKS = 2;

    typedef enum logic {
        BANK5 = 1'b0,
        BANK7 = 1'b1
    } vram_bank_t;

    typedef struct packed {
        vram_bank_t            bank;
        logic [VRAM_OFS_W-1:0] ofs;
        logic [7:0]            data;
    } vram_wr_t;

    typedef enum logic [1:0] {
        IDLE,
        RD,
        RDL,
        WR
    } vram_state_t;
endpackage

// File: rtl/vram_fifo.sv
// CPU write buffer. Entries are presented oldest-first with a valid mask so the
// parent can search them for read bypass; the highest valid index is the newest.
module vram_fifo
    import vram_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic             clk_sys,
    input  logic             reset,
    input  logic             push,
    input  vram_wr_t         push_data,
    input  logic             pop,
    output logic             push_ok,
    output logic             full,
    output logic             empty,
    output vram_wr_t         head,
    output vram_wr_t         entries [DEPTH],
    output logic [DEPTH-1:0] valid
);
    localparam int AW = $clog2(DEPTH);

    vram_wr_t    mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [AW:0] count;
    logic        do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO can still take the push.
    assign push_ok = push && (!full || do_pop);
    assign count   = wr_ptr - rd_ptr;
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk_sys) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= push_data;
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            entries[i] = mem[rd_ptr[AW-1:0] + AW'(i)];
            valid[i]   = ((AW+1)'(i) < count);
        end
    end
endmodule

// File: rtl/vram_ctrl.sv
// Screen-memory controller: snoops CPU writes to pages 5/7 into a 16 KB VRAM and
// serves video fetches, with reads always taking priority over write draining.
module vram_ctrl
    import vram_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk_sys,
    input  logic                  reset,
    input  logic                  ce_7mn,
    input  logic                  cpu_wr,
    input  logic [15:0]           cpu_addr,
    input  logic [7:0]            cpu_din,
    input  logic [2:0]            page_ram,
    input  logic                  m128,
    input  logic                  shadow,
    input  logic [VRAM_OFS_W-1:0] vram_addr,
    output logic [7:0]            vram_dout,
    output logic                  overflow
);
    localparam int RAM_AW = $clog2(VRAM_BANKS) + VRAM_OFS_W;

    vram_state_t           state;
    vram_state_t           state_nx;
    logic                  pending;
    logic                  read_req;
    logic                  wr_hit;
    vram_wr_t              wr_ent;
    logic                  push_ok;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  pop;
    vram_wr_t              fifo_head;
    vram_wr_t              fifo_entries [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] fifo_valid;
    vram_bank_t            rd_bank_now;
    vram_bank_t            rd_bank;
    logic [VRAM_OFS_W-1:0] rd_ofs;
    logic                  ram_we;
    logic [RAM_AW-1:0]     ram_addr;
    logic [7:0]            ram_q;
    logic [7:0]            ram [2**RAM_AW];
    logic                  byp_hit;
    logic [7:0]            byp_data;
    logic                  unused_addr;

    assign unused_addr = cpu_addr[13];
    assign read_req    = ce_7mn | pending;
    assign rd_bank_now = vram_bank_t'(m128 & shadow);

    always_comb begin
        wr_hit      = 1'b0;
        wr_ent.bank = BANK5;
        wr_ent.ofs  = cpu_addr[VRAM_OFS_W-1:0];
        wr_ent.data = cpu_din;
        if (cpu_wr) begin
            if (cpu_addr[15:14] == 2'b01) begin
                wr_hit = 1'b1;
            end else if (cpu_addr[15:14] == 2'b11) begin
                if (page_ram == 3'd5) begin
                    wr_hit = 1'b1;
                end else if (page_ram == 3'd7 && m128) begin
                    wr_hit      = 1'b1;
                    wr_ent.bank = BANK7;
                end
            end
        end
    end

    vram_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .push      (wr_hit),
        .push_data (wr_ent),
        .pop       (pop),
        .push_ok   (push_ok),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head),
        .entries   (fifo_entries),
        .valid     (fifo_valid)
    );

    always_comb begin
        state_nx = state;
        pop      = 1'b0;
        ram_we   = 1'b0;
        ram_addr = {fifo_head.bank, fifo_head.ofs};
        case (state)
            IDLE: begin
                if (read_req)         state_nx = RD;
                else if (!fifo_empty) state_nx = WR;
            end
            RD: begin
                ram_addr = {rd_bank_now, vram_addr};
                state_nx = RDL;
            end
            RDL: state_nx = IDLE;
            WR: begin
                ram_we   = 1'b1;
                pop      = 1'b1;
                state_nx = read_req ? RD : IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (ram_we) ram[ram_addr] <= fifo_head.data;
        ram_q <= ram[ram_addr];
    end

    // Newest match wins: scan oldest to newest, then the entry arriving this cycle.
    always_comb begin
        byp_hit  = 1'b0;
        byp_data = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (fifo_valid[i] && fifo_entries[i].bank == rd_bank && fifo_entries[i].ofs == rd_ofs) begin
                byp_hit  = 1'b1;
                byp_data = fifo_entries[i].data;
            end
        end
        if (push_ok && wr_ent.bank == rd_bank && wr_ent.ofs == rd_ofs) begin
            byp_hit  = 1'b1;
            byp_data = wr_ent.data;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state     <= IDLE;
            pending   <= 1'b0;
            overflow  <= 1'b0;
            vram_dout <= '0;
            rd_bank   <= BANK5;
            rd_ofs    <= '0;
        end else begin
            state   <= state_nx;
            pending <= (state == RD) ? ce_7mn : read_req;
            if (wr_hit && !push_ok) overflow <= 1'b1;
            if (state == RD) begin
                rd_bank <= rd_bank_now;
                rd_ofs  <= vram_addr;
            end
            if (state == RDL) vram_dout <= byp_hit ? byp_data : ram_q;
        end
    end
endmodule

// File: tb/tb_vram_ctrl.sv
// Directed bench for vram_ctrl: decode, bank select, bypass, overflow and reset behaviour.
module tb_vram_ctrl;
    logic        clk_sys = 1'b0;
    logic        reset;
    logic        ce_7mn;
    logic        cpu_wr;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_din;
    logic [2:0]  page_ram;
    logic        m128;
    logic        shadow;
    logic [12:0] vram_addr;
    logic [7:0]  vram_dout;
    logic        overflow;

    int total = 0;
    int bad   = 0;

    always #5 clk_sys = ~clk_sys;

    vram_ctrl #(.FIFO_DEPTH(4)) dut (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .ce_7mn    (ce_7mn),
        .cpu_wr    (cpu_wr),
        .cpu_addr  (cpu_addr),
        .cpu_din   (cpu_din),
        .page_ram  (page_ram),
        .m128      (m128),
        .shadow    (shadow),
        .vram_addr (vram_addr),
        .vram_dout (vram_dout),
        .overflow  (overflow)
    );

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk_sys);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
        cpu_wr   = 1'b1;
        cpu_addr = a;
        cpu_din  = d;
        cyc(1);
        cpu_wr   = 1'b0;
    endtask

    // ce at cycle N; data must be registered by the end of N+2.
    task automatic video_read(input logic [12:0] ofs, input logic [7:0] exp, input string tag);
        vram_addr = ofs;
        ce_7mn    = 1'b1;
        cyc(1);
        ce_7mn    = 1'b0;
        cyc(2);
        check(tag, vram_dout, exp);
        cyc(6);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; ce_7mn = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_din = '0;
        page_ram = 3'd0; m128 = 1'b0; shadow = 1'b0; vram_addr = '0;
        cyc(3);
        reset = 1'b0;
        cyc(1);
        check("rst_dout", vram_dout, 8'h00);
        check("rst_ovf", {7'b0, overflow}, 8'h00);
        check("rst_empty", {7'b0, dut.u_fifo.empty}, 8'h01);

        cpu_write(16'h4000, 8'hAA);
        cyc(8);
        video_read(13'h0000, 8'hAA, "rd_4000");
        cyc(5);
        check("hold", vram_dout, 8'hAA);

        cpu_write(16'h4123, 8'h3C);
        m128 = 1'b1; page_ram = 3'd7;
        cpu_write(16'hC123, 8'h55);
        cyc(6);
        shadow = 1'b1;
        video_read(13'h0123, 8'h55, "bank7");
        shadow = 1'b0;
        video_read(13'h0123, 8'h3C, "bank5_shadow0");
        m128 = 1'b0; shadow = 1'b1;
        video_read(13'h0123, 8'h3C, "shadow_no128");

        cpu_write(16'hC123, 8'h99);
        check("p7_no128_ignored", {7'b0, dut.u_fifo.empty}, 8'h01);
        cyc(6);
        m128 = 1'b1; shadow = 1'b1;
        video_read(13'h0123, 8'h55, "bank7_kept");
        shadow = 1'b0;
        video_read(13'h0123, 8'h3C, "bank5_kept");

        page_ram = 3'd5; m128 = 1'b0;
        cpu_write(16'hC200, 8'h5A);
        cyc(6);
        shadow = 1'b1;
        video_read(13'h0200, 8'h5A, "page5_at_c000");
        shadow = 1'b0;

        cpu_write(16'h4010, 8'h20);
        cyc(6);
        cpu_wr = 1'b1; cpu_addr = 16'h4010; cpu_din = 8'h77;
        ce_7mn = 1'b1; vram_addr = 13'h0010;
        cyc(1);
        cpu_wr = 1'b0; ce_7mn = 1'b0;
        cyc(2);
        check("byp_same_cycle", vram_dout, 8'h77);
        check("byp_still_queued", {7'b0, dut.u_fifo.empty}, 8'h00);
        cyc(6);
        video_read(13'h0010, 8'h77, "after_drain");

        cpu_write(16'h4020, 8'h30);
        cyc(6);
        vram_addr = 13'h0020; ce_7mn = 1'b1;
        cyc(1);
        ce_7mn = 1'b0;
        cyc(1);
        cpu_write(16'h4020, 8'h88);
        check("byp_push_in_rdl", vram_dout, 8'h88);
        cyc(6);
        video_read(13'h0020, 8'h88, "rdl_write_landed");

        cpu_write(16'h4304, 8'hEE);
        cyc(6);
        check("ovf_clear", {7'b0, overflow}, 8'h00);
        ce_7mn = 1'b1;
        cyc(2);
        for (int i = 0; i < 5; i++) begin
            cpu_write(16'h4300 + 16'(i), 8'h11 + 8'(i));
            if (i == 3) check("ovf_at_full", {7'b0, overflow}, 8'h00);
        end
        check("ovf_set", {7'b0, overflow}, 8'h01);
        ce_7mn = 1'b0;
        cyc(14);
        check("ovf_sticky", {7'b0, overflow}, 8'h01);
        for (int i = 0; i < 4; i++)
            video_read(13'h0300 + 13'(i), 8'h11 + 8'(i), "ovf_accepted");
        video_read(13'h0304, 8'hEE, "ovf_dropped");

        m128 = 1'b1; page_ram = 3'd2;
        cpu_write(16'h8000, 8'h01);
        check("ign_8000", {7'b0, dut.u_fifo.empty}, 8'h01);
        cpu_write(16'hC000, 8'h02);
        check("ign_page2", {7'b0, dut.u_fifo.empty}, 8'h01);
        m128 = 1'b0; page_ram = 3'd7;
        cpu_write(16'hC000, 8'h03);
        check("ign_p7_no128", {7'b0, dut.u_fifo.empty}, 8'h01);
        cyc(6);
        video_read(13'h0000, 8'hAA, "ign_ram_unchanged");

        for (int i = 0; i < 3; i++) begin
            cpu_write(16'h4400 + 16'(i), 8'h61 + 8'(i));
            cyc(4);
        end
        cyc(4);
        vram_addr = 13'h0000; ce_7mn = 1'b1;
        cyc(2);
        for (int i = 0; i < 3; i++)
            cpu_write(16'h4400 + 16'(i), 8'hA1 + 8'(i));
        check("pre_rst_queued", {7'b0, dut.u_fifo.empty}, 8'h00);
        ce_7mn = 1'b0;
        reset = 1'b1;
        cyc(2);
        reset = 1'b0;
        check("rst2_dout", vram_dout, 8'h00);
        check("rst2_ovf", {7'b0, overflow}, 8'h00);
        check("rst2_empty", {7'b0, dut.u_fifo.empty}, 8'h01);
        cyc(6);
        for (int i = 0; i < 3; i++)
            video_read(13'h0400 + 13'(i), 8'h61 + 8'(i), "rst_discard");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/vram_ctrl.md
# vram_ctrl

Screen-memory controller that sits directly upstream of the video controller. It captures CPU writes that land in the two screen pages (RAM page 5 and, on 128K machines, page 7) into a 16 KB on-chip single-port VRAM. It serves the video controller's 13-bit `vram_addr` fetches and returns `vram_dout` in time for the next 7 MHz negative-phase strobe. CPU writes are buffered in a small FIFO and drained into the RAM in slots not used by video fetches; a bypass keeps video reads coherent with still-queued writes.

## Interface
Parameters:
- FIFO_DEPTH, 4, write-buffer entries (power of two, ≥2)

Ports:
- clk_sys  in  1  master clock
- reset  in  1  reset, synchronous, active-high
- ce_7mn  in  1  video fetch strobe, same strobe the video controller uses to update `vram_addr`; at most one pulse every 4 clk_sys
- cpu_wr  in  1  one-clk_sys pulse per completed CPU memory write
- cpu_addr  in  16  CPU address of the write
- cpu_din  in  8  CPU write data
- page_ram  in  3  RAM page mapped at 0xC000
- m128  in  1  128K memory map enabled
- shadow  in  1  port 7FFD bit 3, display page 7
- vram_addr  in  13  video fetch offset
- vram_dout  out  8  video fetch data, registered
- overflow  out  1  sticky flag: a write was dropped because the FIFO was full

## Operation
- **Write decode.** On `cpu_wr`, classify the write:
  - `cpu_addr[15:14]==01` → bank 0.
  - `cpu_addr[15:14]==11` and `page_ram==5` → bank 0.
  - `cpu_addr[15:14]==11` and `page_ram==7` and `m128` → bank 1.
  - Anything else is ignored.
- **Queued entry.** An accepted write pushes {bank, `cpu_addr[12:0]`, `cpu_din`} into the FIFO. All 8 KB of each bank is stored, not just the 6912 display bytes.
- **Read bank.** Video read bank = `m128 & shadow`, sampled when the read is issued. RAM address is {bank, offset}, 14 bits.
- **Arbiter FSM** (one RAM access per clk_sys):
  - IDLE: if a ce_7mn pulse is latched pending → RD. Else if the FIFO is non-empty → WR. Else stay in IDLE.
  - RD: drive the RAM with {read bank, `vram_addr`}, clear the pending flag → RDL.
  - RDL: RAM data is available (1-cycle RAM latency). Load `vram_dout` from the RAM data or the bypass result → IDLE.
  - WR: write the FIFO head to RAM, pop → IDLE, or directly → RD if a ce_7mn is pending.
- **Read priority.** A ce_7mn arriving during RD, RDL or WR sets the pending flag. The read is never lost and always has priority over draining.
- **Bypass.** In RDL, compare the read's {bank, offset} against every valid FIFO entry, plus any entry being pushed that cycle. If there is a match, the newest match supplies `vram_dout` in place of the RAM data.
- **FIFO push/pop rules.**
  - Full with no pop that cycle: the push is dropped and `overflow` is set.
  - Full with a pop in the same cycle: the push is accepted.
  - Empty with a push: the entry is not written to RAM in the same cycle; it is eligible next cycle.
- **Wrap.** Pointers are log2(FIFO_DEPTH)+1 bits wide; full/empty come from MSB compare. Offsets never carry into the bank bit.

## Timing
- **Reset values:** `vram_dout`=0x00, `overflow`=0, FSM=IDLE, FIFO empty, pending=0.
- **Reset scope:** RAM contents are not cleared. Reset mid-operation discards queued writes and any pending read.
- **Read latency:** ce_7mn at cycle N → RD at N+1 (IDLE) → `vram_dout` updated at the end of N+2. Worst case, with WR in progress at N+1, it is updated at the end of N+3. It is therefore valid before the next ce_7mn given the 4-clk_sys spacing.
- **Hold:** `vram_dout` holds its value until the next RDL.
- **Drain rate:** at least one write per 4 clk_sys. A 4-deep FIFO cannot overflow when CPU writes are ≥4 clk_sys apart.
- **Simultaneous events:**
  - `cpu_wr` and ce_7mn in the same cycle: both are registered.
  - A write to the address being read in that RDL cycle: the bypass returns the new data.

## Structure
- **Package `vram_pkg`:**
  - constants `VRAM_OFS_W`=13 and `VRAM_BANKS`=2.
  - `vram_bank_t` enum {BANK5, BANK7}.
  - `vram_wr_t` struct {bank, ofs, data}.
  - FSM state enum {IDLE, RD, RDL, WR}.
- **Sub-module `vram_fifo`:** parameterised FIFO of `vram_wr_t` with push/pop/full/empty. It exposes all entries plus a valid mask so the parent can implement the bypass.
- **RAM:** an inferred single-port 16K×8 array inside `vram_ctrl`.

## Test plan
- Reset, then write 0xAA to 0x4000 with ce_7mn spaced ≥8 clk_sys; video then reads offset 0x0000 → `vram_dout`=0xAA within 3 clk_sys of ce_7mn.
- `m128`=1, `page_ram`=7, write 0x55 to 0xC123, `shadow`=1, read offset 0x0123 → 0x55. With `shadow`=0, the same read → the bank 0 value.
- Write 0x77 to 0x4010 on the same cycle as ce_7mn with `vram_addr`=0x0010 → 0x77 via the bypass, before the entry drains.
- Five `cpu_wr` on consecutive cycles with ce_7mn held active → 4 accepted, `overflow`=1 and stays set. Later reads show the four accepted values.
- Writes to 0x8000, and to 0xC000 with `page_ram`=2 → the RAM is unchanged and the FIFO is never pushed.
- Assert reset with 3 writes queued → after reset the FIFO is empty, `vram_dout`=0, and the queued data never appears in RAM.
